// File: rtl/flick_pkg.sv
// Shared types and defaults for the flick push-button pulse generator.
package flick_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StPressDb   = 2'b01,
        StHeld      = 2'b10,
        StReleaseDb = 2'b11
    } flick_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 64;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 16;

    // Bits needed to hold the value max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-high reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/flick_pulse_gen.sv
// Debounced push-button to press/long-press pulse generator.
// Define FLICK_AUTOREPEAT_EN to build the auto-repeat pulse train after a long press.
module flick_pulse_gen
    import flick_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flick_raw,
    output logic       pulse_flick,
    output logic       long_press,
    output logic       pressed,
    output logic [1:0] current_state
);

    localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);

    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 255 || HOLD_CYCLES <= DEBOUNCE_CYCLES
        || REPEAT_CYCLES < 2) begin : g_param_check
        $error("flick_pulse_gen: illegal parameter set");
    end

    logic             w_sync;
    flick_state_e     r_state;
    flick_state_e     w_state_next;
    logic [DbW-1:0]   r_db_cnt;
    logic [DbW-1:0]   w_db_cnt_next;
    logic [HoldW-1:0] r_hold_cnt;
    logic [HoldW-1:0] w_hold_cnt_next;
    logic             w_press_accept;
    logic             w_hold_active;
    logic             w_long_next;
    logic             w_rep_fire;
    logic             r_pulse;
    logic             r_long;

    sync_2ff u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (flick_raw),
        .o_q     (w_sync)
    );

    // Press and release debounce share one counter; only one is ever in progress.
    always_comb begin
        w_state_next   = r_state;
        w_db_cnt_next  = r_db_cnt;
        w_press_accept = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next   = StHeld;
                        w_press_accept = 1'b1;
                    end else begin
                        w_state_next  = StPressDb;
                        w_db_cnt_next = DbW'(1);
                    end
                end
            end
            StPressDb: begin
                if (!w_sync) begin
                    w_state_next  = StIdle;
                    w_db_cnt_next = '0;
                end else if (r_db_cnt >= DbW'(DEBOUNCE_CYCLES - 1)) begin
                    w_state_next   = StHeld;
                    w_db_cnt_next  = '0;
                    w_press_accept = 1'b1;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            StHeld: begin
                if (!w_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next  = StIdle;
                        w_db_cnt_next = '0;
                    end else begin
                        w_state_next  = StReleaseDb;
                        w_db_cnt_next = DbW'(1);
                    end
                end
            end
            StReleaseDb: begin
                if (w_sync) begin
                    w_state_next  = StHeld;
                    w_db_cnt_next = '0;
                end else if (r_db_cnt >= DbW'(DEBOUNCE_CYCLES - 1)) begin
                    w_state_next  = StIdle;
                    w_db_cnt_next = '0;
                end else begin
                    w_db_cnt_next = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next  = StIdle;
                w_db_cnt_next = '0;
            end
        endcase
    end

    // Hold count saturates at HOLD_CYCLES, so long_press can only fire once per press.
    always_comb begin
        w_hold_active   = (r_state == StHeld || r_state == StReleaseDb)
                          && (w_state_next != StIdle);
        w_hold_cnt_next = r_hold_cnt;
        if (w_press_accept || w_state_next == StIdle) begin
            w_hold_cnt_next = '0;
        end else if (w_hold_active && r_hold_cnt != HoldW'(HOLD_CYCLES)) begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
        w_long_next = w_hold_active && (r_hold_cnt == HoldW'(HOLD_CYCLES - 1));
    end

`ifdef FLICK_AUTOREPEAT_EN
    localparam int unsigned RepW = cnt_width(REPEAT_CYCLES);

    logic            r_rep_active;
    logic            w_rep_active_next;
    logic [RepW-1:0] r_rep_cnt;
    logic [RepW-1:0] w_rep_cnt_next;

    // Repeat timer runs only while HELD and freezes through release debounce.
    always_comb begin
        w_rep_active_next = r_rep_active;
        w_rep_cnt_next    = r_rep_cnt;
        w_rep_fire        = 1'b0;
        if (w_state_next == StIdle) begin
            w_rep_active_next = 1'b0;
            w_rep_cnt_next    = '0;
        end else if (w_long_next) begin
            w_rep_active_next = 1'b1;
            w_rep_cnt_next    = '0;
        end else if (r_rep_active && r_state == StHeld) begin
            if (r_rep_cnt == RepW'(REPEAT_CYCLES - 1)) begin
                w_rep_fire     = 1'b1;
                w_rep_cnt_next = '0;
            end else begin
                w_rep_cnt_next = r_rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            r_rep_active <= w_rep_active_next;
            r_rep_cnt    <= w_rep_cnt_next;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_pulse    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_db_cnt   <= w_db_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_pulse    <= w_press_accept | w_rep_fire;
            r_long     <= w_long_next;
        end
    end

    assign pulse_flick   = r_pulse;
    assign long_press    = r_long;
    assign pressed       = (r_state == StHeld) || (r_state == StReleaseDb);
    assign current_state = r_state;

endmodule

// File: tb/tb_flick_pulse_gen.sv
// Scoreboard bench for flick_pulse_gen: stimulus queues expected pulse edges, a monitor pops them.
module tb_flick_pulse_gen;

    localparam int D = 4;
    localparam int H = 64;
    localparam int R = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       flick_raw;
    logic       pulse_flick;
    logic       long_press;
    logic       pressed;
    logic [1:0] current_state;

    typedef struct {
        bit is_long;
        int ev_edge;
    } exp_t;

    exp_t exp_q[$];
    int   edge_no  = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    flick_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flick_raw     (flick_raw),
        .pulse_flick   (pulse_flick),
        .long_press    (long_press),
        .pressed       (pressed),
        .current_state (current_state)
    );

    task automatic tick();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int e);
        while (edge_no < e) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, edge_no, act, req);
        end
    endtask

    function automatic void expect_ev(input bit is_long, input int e);
        exp_t t;
        t.is_long = is_long;
        t.ev_edge = e;
        exp_q.push_back(t);
    endfunction

    task automatic mon_pop(input bit is_long);
        exp_t  t;
        string nm;
        nm = is_long ? "long_press" : "pulse_flick";
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected: actual edge=%0d required=none", nm, edge_no);
        end else begin
            t = exp_q.pop_front();
            if (t.is_long != is_long || t.ev_edge != edge_no) begin
                failures++;
                $display("FAIL %s event: actual kind=%0d edge=%0d required kind=%0d edge=%0d",
                         nm, is_long, edge_no, t.is_long, t.ev_edge);
            end
        end
    endtask

    always @(negedge clk) begin
        if (pulse_flick === 1'b1) mon_pop(1'b0);
        if (long_press === 1'b1) mon_pop(1'b1);
    end

    initial begin
        int n;
        int a;
        int rl;
        reset     = 1'b1;
        flick_raw = 1'b0;
        ticks(3);
        check("reset_state", current_state, 0);
        check("reset_pressed", pressed, 0);
        check("reset_pulse", pulse_flick, 0);
        check("reset_long", long_press, 0);
        reset = 1'b0;

        // 2 ns glitch between edges is never sampled
        ticks(2);
        #2 flick_raw = 1'b1;
        #2 flick_raw = 1'b0;
        ticks(8);
        check("glitch_pressed", pressed, 0);
        check("glitch_state", current_state, 0);

        // 3-cycle high: reaches PRESS_DB count 3, then falls back
        flick_raw = 1'b1;
        n = edge_no + 1;
        ticks(3);
        flick_raw = 1'b0;
        run_to(n + 4);
        check("short_still_press_db", current_state, 1);
        tick();
        check("short_back_idle", current_state, 0);
        ticks(5);
        check("short_pressed", pressed, 0);

        // Clean press held 20 cycles, then bouncy release 0/1/0
        n = edge_no + 1;
        flick_raw = 1'b1;
        expect_ev(1'b0, n + 1 + D);
        run_to(n + D);
        check("press_db_before_held", current_state, 1);
        check("press_not_yet_pressed", pressed, 0);
        tick();
        check("press_held_state", current_state, 2);
        check("press_pressed", pressed, 1);
        run_to(n + 19);
        flick_raw = 1'b0;
        a = n + 20;
        tick();
        flick_raw = 1'b1;
        tick();
        flick_raw = 1'b0;
        run_to(a + 3);
        check("bounce_back_held", current_state, 2);
        run_to(a + 6);
        check("release_db_state", current_state, 3);
        check("release_still_pressed", pressed, 1);
        tick();
        check("release_pressed_low", pressed, 0);
        check("release_idle", current_state, 0);

        // Long hold of 100 cycles
        ticks(5);
        n = edge_no + 1;
        flick_raw = 1'b1;
        expect_ev(1'b0, n + 1 + D);
        expect_ev(1'b1, n + 1 + D + H);
`ifdef FLICK_AUTOREPEAT_EN
        expect_ev(1'b0, n + 1 + D + H + R);
        expect_ev(1'b0, n + 1 + D + H + 2 * R);
`endif
        run_to(n + D + H);
        check("long_held_state", current_state, 2);
        run_to(n + 99);
        flick_raw = 1'b0;
        run_to(n + 125);
        check("long_release_idle", current_state, 0);

        // Reset mid-hold with the button kept down
        ticks(5);
        n = edge_no + 1;
        flick_raw = 1'b1;
        expect_ev(1'b0, n + 1 + D);
        run_to(n + 29);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_state", current_state, 0);
            check("rst_pressed", pressed, 0);
            check("rst_pulse", pulse_flick, 0);
            check("rst_long", long_press, 0);
        end
        reset = 1'b0;
        rl = edge_no;
        expect_ev(1'b0, rl + 2 + D);
        expect_ev(1'b1, rl + 2 + D + H);
        run_to(rl + 1 + D);
        check("rst_redetect_press_db", current_state, 1);
        tick();
        check("rst_redetect_pressed", pressed, 1);
        run_to(rl + 2 + D + H + 3);
        flick_raw = 1'b0;
        run_to(rl + 2 + D + H + 20);
        check("rst_final_idle", current_state, 0);

        ticks(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
